sum_uart_reporter: RTL and testbench

//   Parametrised operand-latch + adder + UART reporter. Captures operands A and B

---
 rtl/sum_uart_reporter.sv | 153 +++++++++++++++
 tb/tb_sum_uart_reporter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_uart_reporter.sv
// Operand latch + registered adder + 8N1 UART reporter of a sum snapshot.
// Define SUM_ASCII_HEX_EN to send uppercase ASCII hex digits plus CR/LF instead of raw bytes.
module sum_uart_reporter #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              uart_tx_en,
  output logic [DATA_W:0]   sum,
  output logic              uart_txd,
  output logic              uart_tx_busy
);

  localparam int SUM_W = DATA_W + 1;
`ifdef SUM_ASCII_HEX_EN
  localparam int ND     = (SUM_W + 3) / 4;
  localparam int NBYTES = ND + 2;
`else
  localparam int NBYTES = (SUM_W + 7) / 8;
`endif
  localparam int BI_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_NEXT} state_t;

  // [0],[1] synchroniser stages, [2] edge-detect history
  logic [2:0] sa_sync, sb_sync, en_sync;
  logic       fall_a, fall_b, rise_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_sync <= 3'b111;
      sb_sync <= 3'b111;
      en_sync <= 3'b000;
    end else begin
      sa_sync <= {sa_sync[1:0], save_a_n};
      sb_sync <= {sb_sync[1:0], save_b_n};
      en_sync <= {en_sync[1:0], uart_tx_en};
    end
  end

  assign fall_a  = sa_sync[2] & ~sa_sync[1];
  assign fall_b  = sb_sync[2] & ~sb_sync[1];
  assign rise_en = en_sync[1] & ~en_sync[2];

  logic [DATA_W-1:0] op_a, op_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a <= '0;
      op_b <= '0;
      sum  <= '0;
    end else begin
      if (fall_a) op_a <= data_input;
      if (fall_b) op_b <= data_input;
      sum <= SUM_W'(op_a) + SUM_W'(op_b);
    end
  end

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       bit_idx, bit_nxt;
  logic [BI_W-1:0]  byte_idx;
  logic [SUM_W-1:0] snap;
  logic [7:0]       cur_byte;
  logic             tmr_done, last_byte, txd_d;

  assign tmr_done  = (tmr == TMR_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == BI_W'(NBYTES - 1));

`ifdef SUM_ASCII_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  logic [ND*4-1:0] snap_hex;
  assign snap_hex = (ND*4)'(snap);

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < ND; k++)
      if (byte_idx == BI_W'(k)) cur_byte = hex_char(snap_hex[(ND-1-k)*4 +: 4]);
    if (byte_idx == BI_W'(ND))     cur_byte = 8'h0D;
    if (byte_idx == BI_W'(ND + 1)) cur_byte = 8'h0A;
  end
`else
  logic [NBYTES*8-1:0] snap_ext;
  assign snap_ext = (NBYTES*8)'(snap);

  // Most-significant byte goes out first
  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++)
      if (byte_idx == BI_W'(k)) cur_byte = snap_ext[(NBYTES-1-k)*8 +: 8];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rise_en) state_nxt = S_START;
      S_START: if (tmr_done) state_nxt = S_DATA;
      S_DATA:  if (tmr_done && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (tmr_done) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_byte ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // txd is precomputed for the state being entered so the pin register
  // switches exactly on bit boundaries.
  always_comb begin
    bit_nxt = 3'd0;
    if (state == S_DATA) bit_nxt = tmr_done ? bit_idx + 3'd1 : bit_idx;
    case (state_nxt)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_byte[bit_nxt];
      default: txd_d = 1'b1;
    endcase
    uart_tx_busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      uart_txd <= 1'b1;
    end else begin
      uart_txd <= txd_d;
      if (state_nxt != state || tmr_done)
        tmr <= '0;
      else if (state == S_START || state == S_DATA || state == S_STOP)
        tmr <= tmr + 1'b1;
      if (state != S_DATA)  bit_idx <= '0;
      else if (tmr_done)    bit_idx <= bit_idx + 3'd1;
      if (state == S_IDLE)      byte_idx <= '0;
      else if (state == S_NEXT) byte_idx <= byte_idx + 1'b1;
      if (state == S_IDLE && rise_en) snap <= sum;
    end
  end

endmodule

// File: tb/tb_sum_uart_reporter.sv
// Directed + randomized bench for sum_uart_reporter: a 4-bit and a 12-bit instance
// checked against an arithmetic model of sums and expected UART line waveforms.
module tb_sum_uart_reporter;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sa_n = 1'b1, sb_n = 1'b1;
  logic [3:0]  d4 = '0;
  logic [11:0] d12 = '0;
  logic        en4 = 1'b0, en12 = 1'b0;
  logic [4:0]  sum4;
  logic [12:0] sum12;
  logic        txd4, txd12, busy4, busy12;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int a4 = 0, b4 = 0, a12 = 0, b12 = 0;

  sum_uart_reporter #(.DATA_W(4), .CLKS_PER_BIT(CPB)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .save_a_n(sa_n), .save_b_n(sb_n),
    .data_input(d4), .uart_tx_en(en4), .sum(sum4), .uart_txd(txd4), .uart_tx_busy(busy4));

  sum_uart_reporter #(.DATA_W(12), .CLKS_PER_BIT(CPB)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .save_a_n(sa_n), .save_b_n(sb_n),
    .data_input(d12), .uart_tx_en(en12), .sum(sum12), .uart_txd(txd12), .uart_tx_busy(busy12));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic txd_of(input bit w);  return w ? txd12 : txd4;  endfunction
  function automatic logic busy_of(input bit w); return w ? busy12 : busy4; endfunction

  task automatic set_en(input bit w, input logic v);
    if (w) en12 = v; else en4 = v;
  endtask

  function automatic int nbytes(input int dw);
`ifdef SUM_ASCII_HEX_EN
    return (dw + 4) / 4 + 2;
`else
    return (dw + 8) / 8;
`endif
  endfunction

  function automatic int exp_byte(input int dw, input int s, input int k);
`ifdef SUM_ASCII_HEX_EN
    int nd = (dw + 4) / 4;
    int dg;
    if (k == nd) return 13;
    if (k == nd + 1) return 10;
    dg = (s >> (4 * (nd - 1 - k))) & 15;
    return (dg < 10) ? 48 + dg : 55 + dg;
`else
    int nb = (dw + 8) / 8;
    return (s >> (8 * (nb - 1 - k))) & 255;
`endif
  endfunction

  // Pulse the selected strobes, holding them low long enough to cross the synchroniser
  task automatic load(input bit do_a, input bit do_b, input int v4, input int v12);
    d4 = v4[3:0]; d12 = v12[11:0];
    if (do_a) sa_n = 1'b0;
    if (do_b) sb_n = 1'b0;
    tick(4);
    sa_n = 1'b1; sb_n = 1'b1;
    if (do_a) begin a4 = v4 & 15; a12 = v12 & 12'hFFF; end
    if (do_b) begin b4 = v4 & 15; b12 = v12 & 12'hFFF; end
    tick(3);
    chk("sum4", 32'(sum4), 32'(a4 + b4));
    chk("sum12", 32'(sum12), 32'(a12 + b12));
  endtask

  // act: 0 plain, 1 second tx_en edge mid-frame, 2 load A=3 mid-frame, 3 hold tx_en high
  task automatic check_frame(input bit which, input int act);
    int dw = which ? 12 : 4;
    int s  = which ? a12 + b12 : a4 + b4;
    int nb = nbytes(dw);
    int len = nb * (10 * CPB + 1);
    int w[$];
    int lat = 0, errs = 0, busy_cnt = 0, quiet = 0;
    for (int k = 0; k < nb; k++) begin
      int b = exp_byte(dw, s, k);
      repeat (CPB) w.push_back(0);
      for (int i = 0; i < 8; i++) repeat (CPB) w.push_back((b >> i) & 1);
      repeat (CPB) w.push_back(1);
      w.push_back(1);
    end
    set_en(which, 1'b1);
    do begin tick(1); lat++; end while (!busy_of(which) && lat < 10);
    chk("trigger_latency", 32'(lat), 32'd3);
    if (act != 3) set_en(which, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (txd_of(which) !== 1'(w[i])) errs++;
      if (busy_of(which) === 1'b1) busy_cnt++;
      if (act == 1 && i == 20) set_en(which, 1'b1);
      if (act == 1 && i == 26) set_en(which, 1'b0);
      if (act == 2 && i == 10) begin d4 = 4'd3; d12 = 12'd3; sa_n = 1'b0; end
      if (act == 2 && i == 14) begin sa_n = 1'b1; a4 = 3; a12 = 3; end
      tick(1);
    end
    chk("frame_txd_errors", 32'(errs), 32'd0);
    chk("frame_busy_clks", 32'(busy_cnt), 32'(len));
    chk("busy_after_frame", 32'(busy_of(which)), 32'd0);
    if (act == 1 || act == 3) begin
      for (int i = 0; i < 8; i++) begin
        if (busy_of(which) !== 1'b0) quiet++;
        tick(1);
      end
      chk("no_retrigger", 32'(quiet), 32'd0);
      set_en(which, 1'b0);
      tick(3);
    end
  endtask

  initial begin
    tick(2);
    chk("reset_sum4", 32'(sum4), 32'd0);
    chk("reset_txd4", 32'(txd4), 32'd1);
    chk("reset_busy4", 32'(busy4), 32'd0);
    reset_n = 1'b1;
    tick(3);
    chk("idle_txd", 32'(txd4), 32'd1);

    // Exact load latency: A register loads on the 3rd clk, sum on the 4th
    d4 = 4'd9; d12 = 12'd9; sa_n = 1'b0;
    tick(3);
    chk("sum_before_update", 32'(sum4), 32'd0);
    tick(1);
    chk("sum_after_4clk", 32'(sum4), 32'd9);
    sa_n = 1'b1; a4 = 9; a12 = 9;
    tick(3);
    load(1'b0, 1'b1, 8, 8);
    chk("sum_0x11", 32'(sum4), 32'h11);
    check_frame(1'b0, 0);

    // Dropped mid-frame edge, then a fresh edge after busy falls
    check_frame(1'b0, 1);
    check_frame(1'b0, 0);
    // Operand change mid-frame must not disturb the snapshot
    check_frame(1'b0, 2);
    chk("sum_0x0B", 32'(sum4), 32'h0B);
    check_frame(1'b0, 3);

    // Held-low strobe loads once even if the bus later changes
    d4 = 4'd5; d12 = 12'd5; sa_n = 1'b0;
    tick(4);
    d4 = 4'd7; d12 = 12'd7;
    tick(4);
    sa_n = 1'b1; a4 = 5; a12 = 5;
    tick(3);
    chk("held_low_once4", 32'(sum4), 32'(a4 + b4));
    chk("held_low_once12", 32'(sum12), 32'(a12 + b12));

    // Both strobes together; extremes and the 12-bit carry case
    load(1'b1, 1'b1, 15, 12'hFFF);
    check_frame(1'b0, 0);
    load(1'b0, 1'b1, 0, 1);
    chk("sum12_0x1000", 32'(sum12), 32'h1000);
    check_frame(1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      load(1'b1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
      load(1'b0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
      check_frame(1'b0, 0);
      check_frame(1'b1, 0);
    end

    // Reset mid-frame takes effect without a clock edge
    en4 = 1'b1;
    tick(20);
    #1 reset_n = 1'b0;
    en4 = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(txd4), 32'd1);
    chk("rst_mid_busy", 32'(busy4), 32'd0);
    chk("rst_mid_sum4", 32'(sum4), 32'd0);
    chk("rst_mid_sum12", 32'(sum12), 32'd0);
    a4 = 0; b4 = 0; a12 = 0; b12 = 0;
    tick(1);
    reset_n = 1'b1;
    tick(6);
    chk("no_resume_busy", 32'(busy4), 32'd0);
    chk("no_resume_txd", 32'(txd4), 32'd1);
    load(1'b1, 1'b0, 6, 300);
    check_frame(1'b0, 0);
    check_frame(1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
